// File: rtl/hazard_if.sv
// ID-stage hazard bundle: pipeline status in, stall/forward selects and scoreboard state out.
// The pipeline drives through the master modport; the scoreboard uses the slave modport.
interface hazard_if #(
  parameter int NREG = 32
);
  localparam int RW = $clog2(NREG);

  logic            flush;
  logic            ds_valid;
  logic [RW-1:0]   ds_rj;
  logic [RW-1:0]   ds_rk;
  logic            ds_rj_used;
  logic            ds_rk_used;
  logic            ds_issue;
  logic            ds_gr_we;
  logic [RW-1:0]   ds_dest;
  logic            es_valid;
  logic            es_gr_we;
  logic            es_is_load;
  logic [RW-1:0]   es_dest;
  logic            ms_valid;
  logic            ms_gr_we;
  logic            ms_is_load;
  logic            ms_data_ok;
  logic [RW-1:0]   ms_dest;
  logic            ws_rf_we;
  logic [RW-1:0]   ws_dest;
  logic            ds_stall;
  logic [1:0]      fwd_rj_sel;
  logic [1:0]      fwd_rk_sel;
  logic [NREG-1:0] sb_busy;
  logic [1:0]      sb_err;

  modport master (
    output flush, ds_valid, ds_rj, ds_rk, ds_rj_used, ds_rk_used, ds_issue, ds_gr_we, ds_dest,
           es_valid, es_gr_we, es_is_load, es_dest, ms_valid, ms_gr_we, ms_is_load, ms_data_ok,
           ms_dest, ws_rf_we, ws_dest,
    input  ds_stall, fwd_rj_sel, fwd_rk_sel, sb_busy, sb_err
  );

  modport slave (
    input  flush, ds_valid, ds_rj, ds_rk, ds_rj_used, ds_rk_used, ds_issue, ds_gr_we, ds_dest,
           es_valid, es_gr_we, es_is_load, es_dest, ms_valid, ms_gr_we, ms_is_load, ms_data_ok,
           ms_dest, ws_rf_we, ws_dest,
    output ds_stall, fwd_rj_sel, fwd_rk_sel, sb_busy, sb_err
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: pending-write counters per GPR, load-use stalls and forward selects.
// Counter cell first, then the top that instantiates one cell per tracked register.
module hazard_cnt #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic inc,        // already masked by flush at the top
    input  logic dec,
    input  logic drain_done,
    output logic busy,
    output logic ovf,
    output logic unf
);
    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || flush)
            cnt <= '0;
        else if (inc && !dec) begin
            if (cnt != MAX) cnt <= cnt + 1'b1;
        end else if (dec && !inc) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);
    assign ovf  = inc && !dec && (cnt == MAX);
    // Commits of writers killed by a flush land on a zeroed counter; only flag once drained.
    assign unf  = dec && !inc && (cnt == '0) && drain_done;
endmodule

module hazard_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2,
    parameter int DRAIN = 3
) (
    input logic    clk,
    input logic    reset,
    hazard_if.slave sb
);
    localparam int RW = $clog2(NREG);
    localparam int DW = $clog2(DRAIN + 1);

    logic [NREG-1:0] inc, dec, busy, ovf, unf;
    logic [DW-1:0]   drain_cnt;
    logic [1:0]      err_q;

    always_ff @(posedge clk) begin
        if (reset)
            drain_cnt <= '0;
        else if (sb.flush)
            drain_cnt <= DW'(DRAIN);
        else if (drain_cnt != '0)
            drain_cnt <= drain_cnt - 1'b1;
    end

    genvar i;
    generate
        for (i = 0; i < NREG; i++) begin : g_reg
            if (i == 0) begin : g_zero
                assign inc[i]  = 1'b0;
                assign dec[i]  = 1'b0;
                assign busy[i] = 1'b0;
                assign ovf[i]  = 1'b0;
                assign unf[i]  = 1'b0;
            end else begin : g_cnt
                assign inc[i] = sb.ds_issue && sb.ds_gr_we && !sb.flush && (sb.ds_dest == RW'(i));
                assign dec[i] = sb.ws_rf_we && (sb.ws_dest == RW'(i));
                hazard_cnt #(.CNT_W(CNT_W)) u_cnt (
                    .clk        (clk),
                    .reset      (reset),
                    .flush      (sb.flush),
                    .inc        (inc[i]),
                    .dec        (dec[i]),
                    .drain_done (drain_cnt == '0),
                    .busy       (busy[i]),
                    .ovf        (ovf[i]),
                    .unf        (unf[i])
                );
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) err_q <= '0;
        else       err_q <= err_q | {|unf, |ovf};
    end

    // Returns {stall, sel}; youngest matching stage wins, counters catch writers not yet visible.
    function automatic logic [2:0] src_chk(input logic used, input logic [RW-1:0] s);
        logic [2:0] r;
        r = 3'b000;
        if (sb.ds_valid && used && s != '0) begin
            if (sb.es_valid && sb.es_gr_we && sb.es_dest == s)
                r = sb.es_is_load ? 3'b100 : 3'b001;
            else if (sb.ms_valid && sb.ms_gr_we && sb.ms_dest == s)
                r = (sb.ms_is_load && !sb.ms_data_ok) ? 3'b100 : 3'b010;
            else if (sb.ws_rf_we && sb.ws_dest == s)
                r = 3'b011;
            else if (busy[s])
                r = 3'b100;
        end
        return r;
    endfunction

    logic [2:0] rj_res, rk_res;

    always_comb begin
        rj_res = src_chk(sb.ds_rj_used, sb.ds_rj);
        rk_res = src_chk(sb.ds_rk_used, sb.ds_rk);
    end

    assign sb.ds_stall   = rj_res[2] || rk_res[2] || sb.flush;
    assign sb.fwd_rj_sel = rj_res[1:0];
    assign sb.fwd_rk_sel = rk_res[1:0];
    assign sb.sb_busy    = busy;
    assign sb.sb_err     = err_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: per-cycle expectations queued at drive time,
// popped to check the ID outputs before the edge and the scoreboard state after it.
module tb_hazard_scoreboard;
    localparam int NREG = 32;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    hazard_if #(.NREG(NREG)) bus ();

    hazard_scoreboard #(.NREG(NREG), .CNT_W(2), .DRAIN(3)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           tag;
        logic            stall;
        logic [1:0]      rj;
        logic [1:0]      rk;
        logic [NREG-1:0] busy;
        logic [1:0]      err;
    } exp_t;

    exp_t q[$];

    task automatic clr();
        bus.flush = 0; bus.ds_valid = 0; bus.ds_rj = 0; bus.ds_rk = 0;
        bus.ds_rj_used = 0; bus.ds_rk_used = 0; bus.ds_issue = 0; bus.ds_gr_we = 0;
        bus.ds_dest = 0; bus.es_valid = 0; bus.es_gr_we = 0; bus.es_is_load = 0;
        bus.es_dest = 0; bus.ms_valid = 0; bus.ms_gr_we = 0; bus.ms_is_load = 0;
        bus.ms_data_ok = 0; bus.ms_dest = 0; bus.ws_rf_we = 0; bus.ws_dest = 0;
    endtask

    task automatic chk1(input string tag, input string what, input logic [NREG-1:0] obs,
                        input logic [NREG-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s %s: got %h want %h", tag, what, obs, exp);
        end
    endtask

    // Inputs are already driven for this cycle; queue expectations, then check both halves.
    task automatic step(input string tag, input logic st, input logic [1:0] rj,
                        input logic [1:0] rk, input logic [NREG-1:0] busy, input logic [1:0] err);
        exp_t e;
        e.tag = tag; e.stall = st; e.rj = rj; e.rk = rk; e.busy = busy; e.err = err;
        q.push_back(e);
        #2;
        e = q.pop_front();
        chk1(e.tag, "ds_stall", NREG'(bus.ds_stall), NREG'(e.stall));
        chk1(e.tag, "fwd_rj_sel", NREG'(bus.fwd_rj_sel), NREG'(e.rj));
        chk1(e.tag, "fwd_rk_sel", NREG'(bus.fwd_rk_sel), NREG'(e.rk));
        @(posedge clk); #1;
        chk1(e.tag, "sb_busy", bus.sb_busy, e.busy);
        chk1(e.tag, "sb_err", NREG'(bus.sb_err), NREG'(e.err));
        @(negedge clk);
        clr();
    endtask

    task automatic issue(input logic [4:0] d);
        bus.ds_valid = 1; bus.ds_issue = 1; bus.ds_gr_we = 1; bus.ds_dest = d;
    endtask

    task automatic commit(input logic [4:0] d);
        bus.ws_rf_we = 1; bus.ws_dest = d;
    endtask

    initial begin
        reset = 1; clr();
        @(negedge clk);
        step("rst", 0, 0, 0, 0, 2'b00);
        reset = 0;

        // EX and WB forwarding of an ALU result
        issue(5);                                   step("t1_issue", 0, 0, 0, 32'h20, 2'b00);
        bus.ds_valid = 1; bus.ds_rj = 5; bus.ds_rj_used = 1;
        bus.es_valid = 1; bus.es_gr_we = 1; bus.es_dest = 5;
                                                    step("t1_exfwd", 0, 1, 0, 32'h20, 2'b00);
        bus.ds_valid = 1; bus.ds_rj = 5; bus.ds_rj_used = 1; commit(5);
                                                    step("t1_wbfwd", 0, 3, 0, 0, 2'b00);

        // load-use
        bus.ds_valid = 1; bus.ds_rk = 6; bus.ds_rk_used = 1;
        bus.es_valid = 1; bus.es_gr_we = 1; bus.es_is_load = 1; bus.es_dest = 6;
                                                    step("t2_lduse", 1, 0, 0, 0, 2'b00);
        bus.ds_valid = 1; bus.ds_rk = 6; bus.ds_rk_used = 1;
        bus.ms_valid = 1; bus.ms_gr_we = 1; bus.ms_is_load = 1; bus.ms_dest = 6;
                                                    step("t2_memwait", 1, 0, 0, 0, 2'b00);
        bus.ds_valid = 1; bus.ds_rk = 6; bus.ds_rk_used = 1;
        bus.ms_valid = 1; bus.ms_gr_we = 1; bus.ms_is_load = 1; bus.ms_dest = 6; bus.ms_data_ok = 1;
                                                    step("t2_memfwd", 0, 0, 2, 0, 2'b00);
        bus.ds_valid = 1; bus.ds_rj = 6; bus.ds_rk = 6; bus.ds_rj_used = 1; bus.ds_rk_used = 1;
        bus.es_valid = 1; bus.es_gr_we = 1; bus.es_dest = 6;
        bus.ms_valid = 1; bus.ms_gr_we = 1; bus.ms_dest = 6;
                                                    step("t2_prio", 0, 1, 1, 0, 2'b00);
        bus.ds_rj = 6; bus.ds_rj_used = 1;
        bus.es_valid = 1; bus.es_gr_we = 1; bus.es_is_load = 1; bus.es_dest = 6;
                                                    step("t2_inactive", 0, 0, 0, 0, 2'b00);

        // counter stall and simultaneous inc/dec
        issue(7);                                   step("t3_issue", 0, 0, 0, 32'h80, 2'b00);
        bus.ds_valid = 1; bus.ds_rj = 7; bus.ds_rj_used = 1;
                                                    step("t3_cntstall", 1, 0, 0, 32'h80, 2'b00);
        issue(7); commit(7);                        step("t3_incdec", 0, 0, 0, 32'h80, 2'b00);
        commit(7);                                  step("t3_commit", 0, 0, 0, 0, 2'b00);

        // saturation and overflow flag; three commits prove the counter held at 3
        issue(8);                                   step("t4_i1", 0, 0, 0, 32'h100, 2'b00);
        issue(8);                                   step("t4_i2", 0, 0, 0, 32'h100, 2'b00);
        issue(8);                                   step("t4_i3", 0, 0, 0, 32'h100, 2'b00);
        issue(8);                                   step("t4_ovf", 0, 0, 0, 32'h100, 2'b01);
        commit(8);                                  step("t4_c1", 0, 0, 0, 32'h100, 2'b01);
        commit(8);                                  step("t4_c2", 0, 0, 0, 32'h100, 2'b01);
        commit(8);                                  step("t4_c3", 0, 0, 0, 0, 2'b01);

        // r0 is never tracked or forwarded
        bus.ds_valid = 1; bus.ds_rj = 0; bus.ds_rk = 0; bus.ds_rj_used = 1; bus.ds_rk_used = 1;
        bus.es_valid = 1; bus.es_gr_we = 1; bus.es_dest = 0;
        bus.ds_issue = 1; bus.ds_gr_we = 1; bus.ds_dest = 0;
                                                    step("t6_r0", 0, 0, 0, 0, 2'b01);
        issue(10);                                  step("t6_i10", 0, 0, 0, 32'h400, 2'b01);
        reset = 1;                                  step("t6_reset", 0, 0, 0, 0, 2'b00);
        reset = 0;

        // flush clears counters, drains, then underflow becomes visible
        issue(9);                                   step("t5_i1", 0, 0, 0, 32'h200, 2'b00);
        issue(9);                                   step("t5_i2", 0, 0, 0, 32'h200, 2'b00);
        bus.flush = 1; issue(11);                   step("t5_flush", 1, 0, 0, 0, 2'b00);
        commit(9);                                  step("t5_drain1", 0, 0, 0, 0, 2'b00);
        commit(9);                                  step("t5_drain2", 0, 0, 0, 0, 2'b00);
                                                    step("t5_idle", 0, 0, 0, 0, 2'b00);
        commit(9);                                  step("t5_unf", 0, 0, 0, 0, 2'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
